// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point types and format helpers.
//   fp_format_e   - supported binary interchange formats
//   roundmode_e   - IEEE-754 rounding modes
//   uround_res_t  - unrounded result handed from the arithmetic units to the
//                   rounding stage (u_result is sized for the widest format;
//                   narrower formats use the low bits)
//   fp_encoding_t - field view of an FP32 encoding
//   fflags_t      - exception flags {NV, DZ, OF, UF, NX}
package fp_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  localparam int unsigned FP_MAX_WIDTH = 64;

  typedef struct packed {
    logic [FP_MAX_WIDTH-1:0] u_result;
    logic [1:0]              rs;        // {round, sticky}
    logic                    round_en;
    logic                    invalid;
    logic [1:0]              exp_cout;  // 01: overflow, 10: underflow
  } uround_res_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp_encoding_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

endpackage

// File: rtl/fp_rnd_core.sv
// fp_rnd_core: purely combinational IEEE-754 rounding of an unrounded result.
// Ports:
//   urnd_result_i - unrounded payload (u_result, rs, round_en, invalid, exp_cout)
//   rnd_i         - rounding mode
//   result_o      - rounded encoding, FP_WIDTH bits
//   fflags_o      - {NV, DZ, OF, UF, NX}
module fp_rnd_core
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT),
  localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT),
  localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT)
) (
  input  uround_res_t         urnd_result_i,
  input  roundmode_e          rnd_i,
  output logic [FP_WIDTH-1:0] result_o,
  output fflags_t             fflags_o
);

  function automatic logic round_inc(roundmode_e mode, logic sign, logic lsb,
                                     logic r, logic s);
    case (mode)
      RNE:     return r & (s | lsb);
      RTZ:     return 1'b0;
      RDN:     return sign & (r | s);
      RUP:     return ~sign & (r | s);
      RMM:     return r;
      default: return 1'b0;
    endcase
  endfunction

  // Overflow saturates to infinity only when the mode rounds away from zero
  // in the direction of the result's sign.
  function automatic logic ovf_to_inf(roundmode_e mode, logic sign);
    case (mode)
      RNE, RMM: return 1'b1;
      RUP:      return ~sign;
      RDN:      return sign;
      default:  return 1'b0;
    endcase
  endfunction

  logic [FP_WIDTH-1:0]             u;
  logic                            sign;
  logic                            inc;
  logic [EXP_WIDTH+MANT_WIDTH-1:0] sum;
  logic [EXP_WIDTH-1:0]            post_exp;
  logic                            nx;

  if (FP_WIDTH < FP_MAX_WIDTH) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^urnd_result_i.u_result[FP_MAX_WIDTH-1:FP_WIDTH];
  end

  always_comb begin
    u        = urnd_result_i.u_result[FP_WIDTH-1:0];
    sign     = u[FP_WIDTH-1];
    inc      = round_inc(rnd_i, sign, u[0], urnd_result_i.rs[1], urnd_result_i.rs[0]);
    // Mantissa carry ripples into the exponent through the shared adder.
    sum      = u[FP_WIDTH-2:0] + (EXP_WIDTH+MANT_WIDTH)'(inc);
    post_exp = sum[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    nx       = |urnd_result_i.rs;

    result_o    = u;
    fflags_o    = '0;
    fflags_o.nv = urnd_result_i.invalid;

    if (urnd_result_i.round_en) begin
      if (urnd_result_i.exp_cout == 2'b10) begin
        result_o    = {sign, {(FP_WIDTH-1){1'b0}}};
        fflags_o.uf = 1'b1;
        fflags_o.nx = 1'b1;
      end else if (urnd_result_i.exp_cout == 2'b01 || (&post_exp)) begin
        if (ovf_to_inf(rnd_i, sign))
          result_o = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        else
          result_o = {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
        fflags_o.of = 1'b1;
        fflags_o.nx = 1'b1;
      end else begin
        result_o    = {sign, sum};
        fflags_o.nx = nx;
        fflags_o.uf = nx & (post_exp == '0);
      end
    end
  end

endmodule

// File: rtl/fp_round_stage.sv
// fp_round_stage: two-entry registered rounding stage at the consumer end of
// the unrounded-result interface. Captures a payload on a done pulse, rounds
// it combinationally into the output register and presents it valid/ready.
// Ports:
//   clk_i, reset_i       - clock, synchronous active-high reset
//   valid_i              - one-cycle done pulse qualifying urnd_result_i/rnd_i
//   urnd_result_i, rnd_i - unrounded payload and rounding mode
//   busy_o               - both entries full and stalled; valid_i is dropped
//   overrun_o            - sticky: a valid_i arrived while busy_o
//   valid_o, ready_i     - output handshake
//   result_o, fflags_o   - rounded encoding and {NV, DZ, OF, UF, NX}
// Optional (macro FP_ROUND_ACC_FLAGS_EN):
//   clr_flags_i          - clears the accumulated flags (wins over accumulate)
//   fflags_acc_o         - OR of fflags_o over every output handshake
module fp_round_stage
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  uround_res_t         urnd_result_i,
  input  roundmode_e          rnd_i,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [FP_WIDTH-1:0] result_o,
`ifdef FP_ROUND_ACC_FLAGS_EN
  input  logic                clr_flags_i,
  output logic [4:0]          fflags_acc_o,
`endif
  output logic [4:0]          fflags_o
);

  logic                vld_p1;
  uround_res_t         res_p1;
  roundmode_e          rnd_p1;
  logic                vld_p2;
  logic [FP_WIDTH-1:0] result_p2;
  fflags_t             fflags_p2;
  logic [FP_WIDTH-1:0] rnd_result;
  fflags_t             rnd_fflags;
  logic                adv;
  logic                accept;

  assign adv    = vld_p1 & (~vld_p2 | ready_i);
  assign busy_o = vld_p1 & vld_p2 & ~ready_i;
  assign accept = valid_i & ~busy_o;

  // Stage p1: capture payload. When not busy, s1 is either empty or
  // advancing, so a new capture never overwrites a held entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (accept)
        vld_p1 <= 1'b1;
      else if (adv)
        vld_p1 <= 1'b0;
      if (valid_i & busy_o)
        overrun_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      res_p1 <= urnd_result_i;
      rnd_p1 <= rnd_i;
    end
  end

  fp_rnd_core #(
    .FP_FORMAT(FP_FORMAT)
  ) u_rnd_core (
    .urnd_result_i(res_p1),
    .rnd_i        (rnd_p1),
    .result_o     (rnd_result),
    .fflags_o     (rnd_fflags)
  );

  // Stage p2: output register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      fflags_p2 <= '0;
    end else if (adv) begin
      vld_p2    <= 1'b1;
      result_p2 <= rnd_result;
      fflags_p2 <= rnd_fflags;
    end else if (ready_i) begin
      vld_p2 <= 1'b0;
    end
  end

  assign valid_o  = vld_p2;
  assign result_o = result_p2;
  assign fflags_o = fflags_p2;

`ifdef FP_ROUND_ACC_FLAGS_EN
  logic [4:0] fflags_acc;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_flags_i)
      fflags_acc <= '0;
    else if (vld_p2 & ready_i)
      fflags_acc <= fflags_acc | fflags_p2;
  end

  assign fflags_acc_o = fflags_acc;
`endif

endmodule

// File: doc/fp_round_stage.md
Name: fp_round_stage

Overview:
- Consumer end of the unrounded-result interface driven by the FP arithmetic units (sqrt, div, and others).
- Captures a `uround_res_t` on a one-cycle done pulse and applies the IEEE-754 rounding mode.
- Resolves overflow, underflow and special cases, and emits the final encoded result plus fflags through a valid/ready output port.
- Two-entry registered pipeline, so an upstream done pulse needs no backpressure unless both entries are occupied.

Parameters:
- FP_FORMAT, FP32, `fp_format_e` selecting the format. FP_WIDTH, EXP_WIDTH and MANT_WIDTH are derived localparams using the `fp_pkg` functions.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- valid_i  in  1  one-cycle pulse; `urnd_result_i` and `rnd_i` are valid this cycle (connects to the unit's `done_o`)
- urnd_result_i  in  `uround_res_t`  unrounded result: `u_result`, `rs` (round, sticky), `round_en`, `invalid`, `exp_cout`
- rnd_i  in  `roundmode_e`  rounding mode sampled with `valid_i`
- busy_o  out  1  both entries full and output stalled; a `valid_i` this cycle is dropped
- overrun_o  out  1  sticky: set when `valid_i` arrives while `busy_o`=1; cleared only by reset
- valid_o  out  1  `result_o` and `fflags_o` are valid
- ready_i  in  1  downstream accepts when `valid_o & ready_i`
- result_o  out  FP_WIDTH  rounded encoding
- fflags_o  out  5  {NV, DZ, OF, UF, NX}

Behaviour:
- Reset: s1_valid=0, s2_valid=0, `valid_o`=0, `result_o`=0, `fflags_o`=0, `busy_o`=0, `overrun_o`=0. Reset mid-operation discards in-flight entries.
- Stage s1 registers the payload and `rnd_i` on `valid_i & ~busy_o`.
- The rounding logic is combinational from s1 into output register s2.
- Latency: `valid_i` in cycle N gives `valid_o` in cycle N+2 when unstalled. Throughput is 1 per cycle.
- Advance rule: s1 moves to s2 iff `s1_valid & (~s2_valid | ready_i)`. s2 holds while `valid_o & ~ready_i`.
- `busy_o` = `s1_valid & s2_valid & ~ready_i`.
- Simultaneous s1 advance and `valid_i` (not busy): s1 reloads with the new payload, with no bubble.
- Rounding applies only when `round_en`=1. Otherwise `u_result` passes through unchanged; NV=`invalid`; all other flags are 0.
- Increment inc, with lsb = `mant[0]`, r = `rs[1]`, s = `rs[0]`:
  - RNE: r & (s | lsb)
  - RTZ: 0
  - RDN: sign & (r | s)
  - RUP: ~sign & (r | s)
  - RMM: r
- {exp, mant} + inc is computed at EXP_WIDTH+MANT_WIDTH bits. A mantissa carry propagates into exp.
- Overflow occurs when `exp_cout`==2'b01, or when the post-increment exp is all ones.
  - Result is ±inf for RNE/RMM, for RUP when positive, and for RDN when negative.
  - Otherwise the result is ±max-normal (exp all ones minus 1, mant all ones).
  - Sets OF=1 and NX=1.
- Underflow occurs when `exp_cout`==2'b10: result is signed zero, UF=1, NX=1.
- NX = r | s otherwise.
- UF = NX & (post-round exp==0).
- NV = `invalid`. DZ is always 0 (division-by-zero is signalled through `invalid`-free pass-through by the divider's own path).

Optional Feature:
- FP_ROUND_ACC_FLAGS_EN defined: adds ports `clr_flags_i` (in, 1) and `fflags_acc_o` (out, 5).
  - `fflags_acc_o` ORs in `fflags_o` on every `valid_o & ready_i` handshake.
  - `clr_flags_i` zeroes it next cycle; clear wins over a same-cycle accumulate.
  - Reset value is 0.
- Undefined: those ports and the accumulation register are absent.

Decomposition:
- `uround_res_t`, `roundmode_e` and `fp_encoding_t` stay in `fp_pkg`.
- Add `fflags_t` (packed NV, DZ, OF, UF, NX) to `fp_pkg`.
- One natural sub-module: `fp_rnd_core`. It is purely combinational: payload plus mode in, result plus flags out, and it is reusable by other units.

Test Plan:
- FP32, RNE, `u_result`=0x3F800000, `rs`=2'b11, `round_en`=1 → `result_o`=0x3F800001, `fflags_o`=00001, `valid_o` exactly 2 cycles after `valid_i`.
- RNE, mant=0x7FFFFF, exp=0x7E, `rs`=2'b10 → carry into exp, `result_o`=0x3F800000, NX=1. With RTZ the same input gives 0x3F7FFFFF.
- Overflow:
  - `exp_cout`=01, sign=1, RDN → 0xFF800000, flags 00101.
  - RUP with the same input → 0xFF7FFFFF, flags 00101.
- `round_en`=0, `invalid`=1, `u_result`=0xFFC00000 → passes through unchanged, `fflags_o`=10000.
- Hold `ready_i`=0 and pulse `valid_i` 3 times back to back:
  - first two captured; `busy_o`=1 on the third; `overrun_o` goes to 1.
  - release `ready_i`: two results emerge in order.
- Reset asserted while s1 and s2 are full → next cycle `valid_o`=0 and `busy_o`=0; the following `valid_i` yields a single correct output.
